// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and default constants for the hazard scoreboard.
//   NREGS_DEF      : default architectural register count (r0 hardwired zero)
//   DEPTH_DEF      : default number of tracked stages after decode (1 = EX)
//   LOAD_STAGE_DEF : default first stage whose output carries load data
//   sb_entry_t     : one scoreboard entry {valid, dst, wen, load}
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int NREGS_DEF      = 32;
  localparam int DEPTH_DEF      = 3;
  localparam int LOAD_STAGE_DEF = 2;

  // The dst field is sized for up to 256 registers so a single entry type
  // serves every NREGS setting; narrower register numbers are zero-extended.
  localparam int SB_DST_W       = 8;

  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic                wen;
    logic                load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Priority search of the scoreboard for one decode source operand.
// Finds the youngest in-flight writer of the source and reports where its
// result can be forwarded from, or requests a stall when that writer is a
// load whose data is not yet available.
// Ports:
//   i_ent   [1:DEPTH] : scoreboard entries, index k = pipeline stage k
//   i_src             : source register number
//   i_use             : source is actually read
//   o_fwd             : 0 = register file, k = stage-k result
//   o_stall           : youngest writer is a load still ahead of LOAD_STAGE
// -----------------------------------------------------------------------------
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NREGS      = NREGS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF
) (
  input  sb_entry_t                    i_ent [1:DEPTH],
  input  logic [$clog2(NREGS)-1:0]     i_src,
  input  logic                         i_use,
  output logic [$clog2(DEPTH+1)-1:0]   o_fwd,
  output logic                         o_stall
);

  localparam int FW = $clog2(DEPTH+1);

  logic [FW-1:0] w_k;
  logic          w_hit;
  logic          w_load;
  logic          w_early;

  always_comb begin
    w_hit   = 1'b0;
    w_k     = '0;
    w_load  = 1'b0;
    w_early = 1'b0;
    if (i_use && (i_src != '0)) begin
      // Scan oldest to youngest so the youngest matching writer wins.
      for (int k = DEPTH; k >= 1; k--) begin
        if (i_ent[k].valid && i_ent[k].wen &&
            (i_ent[k].dst == SB_DST_W'(i_src))) begin
          w_hit   = 1'b1;
          w_k     = FW'(k);
          w_load  = i_ent[k].load;
          w_early = (k < LOAD_STAGE);
        end
      end
    end
    o_stall = w_hit & w_load & w_early;
    // A source that must wait for load data does not forward anything.
    o_fwd   = (w_hit && !o_stall) ? w_k : '0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks the destination registers of the DEPTH instructions in flight after
// decode, selects forwarding sources for the two decode operands and raises a
// load-use stall when a load result is not available in time.
// Optional feature: define HAZARD_STATS_EN to add the stall_cycles counter.
// Ports:
//   CLK, nRST            : clock (rising edge), synchronous active-low reset
//   id_valid             : decode holds a valid instruction
//   id_rs, id_rt         : decode source registers
//   id_use_rs, id_use_rt : matching source is actually read
//   id_dst               : decode destination register
//   id_wen, id_load      : instruction writes a register / is a load
//   freeze               : whole-pipeline hold
//   flush                : discard the decode instruction
//   fwd_a, fwd_b         : forwarding select (0 = register file, k = stage k)
//   stall                : hold fetch/decode and insert a bubble
//   stall_cycles         : (HAZARD_STATS_EN only) saturating stall counter
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS      = NREGS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         id_valid,
  input  logic [$clog2(NREGS)-1:0]     id_rs,
  input  logic [$clog2(NREGS)-1:0]     id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic [$clog2(NREGS)-1:0]     id_dst,
  input  logic                         id_wen,
  input  logic                         id_load,
  input  logic                         freeze,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic                         stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam int FW = $clog2(DEPTH+1);

  sb_entry_t     r_ent [1:DEPTH];
  logic [FW-1:0] w_fwd_a;
  logic [FW-1:0] w_fwd_b;
  logic          w_stall_a;
  logic          w_stall_b;
  logic          w_stall;
  logic          w_issue;

  hazard_match #(
    .NREGS      (NREGS),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_match_rs (
    .i_ent   (r_ent),
    .i_src   (id_rs),
    .i_use   (id_use_rs),
    .o_fwd   (w_fwd_a),
    .o_stall (w_stall_a)
  );

  hazard_match #(
    .NREGS      (NREGS),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_match_rt (
    .i_ent   (r_ent),
    .i_src   (id_rt),
    .i_use   (id_use_rt),
    .o_fwd   (w_fwd_b),
    .o_stall (w_stall_b)
  );

  // Outputs are gated by nRST so they read quiet while reset is held, even
  // before the first reset edge has cleared the entries.
  assign w_stall = nRST & ~flush & (w_stall_a | w_stall_b);
  assign stall   = w_stall;
  assign fwd_a   = nRST ? w_fwd_a : '0;
  assign fwd_b   = nRST ? w_fwd_b : '0;
  assign w_issue = id_valid & ~w_stall & ~flush;

  // Stage boundary: decode -> stage 1 -> ... -> stage DEPTH (retire).
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_ent[k].valid <= 1'b0;
      end
    end else if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_ent[k] <= r_ent[k-1];
      end
      // A stalled or flushed decode enters stage 1 as a bubble (valid=0).
      r_ent[1] <= '{valid: w_issue,
                    dst:   SB_DST_W'(id_dst),
                    wen:   id_wen,
                    load:  id_load};
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stall_cycles;

  // Only stall cycles that actually cost a bubble are counted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !freeze) begin
      r_stall_cycles <= sat_inc16(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard: a table of per-cycle decode inputs with
// hand-computed fwd/stall values, followed by hand-written freeze and
// reset-mid-stall sequences. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_wen;
  logic       id_load;
  logic       freeze;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  hazard_scoreboard dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_dst    (id_dst),
    .id_wen    (id_wen),
    .id_load   (id_load),
    .freeze    (freeze),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    logic       rstn;
    logic       frz;
    logic       fl;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       wen;
    logic       ld;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rstn, input logic frz, input logic fl,
                     input logic v, input int rs, input int rt,
                     input logic urs, input logic urt, input int dst,
                     input logic wen, input logic ld,
                     input int fa, input int fb, input logic st);
    vec_t e;
    e.rstn = rstn; e.frz = frz; e.fl = fl; e.v = v;
    e.rs = 5'(rs); e.rt = 5'(rt); e.urs = urs; e.urt = urt;
    e.dst = 5'(dst); e.wen = wen; e.ld = ld;
    e.fa = 2'(fa); e.fb = 2'(fb); e.st = st;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic rstn, input logic frz, input logic fl,
                       input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int dst,
                       input logic wen, input logic ld);
    nRST = rstn; freeze = frz; flush = fl; id_valid = v;
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_dst = 5'(dst); id_wen = wen; id_load = ld;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input int fa, input int fb, input int st);
    chk({tag, "_fwd_a"}, int'(fwd_a), fa);
    chk({tag, "_fwd_b"}, int'(fwd_b), fb);
    chk({tag, "_stall"}, int'(stall), st);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef HAZARD_STATS_EN
    chk({tag, "_stall_cycles"}, int'(stall_cycles), exp);
`else
    if (tag.len() < 0) $display("%0d", exp);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rstn frz fl v  rs rt urs urt dst wen ld   fa fb st
    add(0, 0, 0, 1,  1,  2, 1, 1,  3, 1, 0,  0, 0, 0); // 0  reset held
    add(1, 0, 0, 1,  1,  2, 1, 1,  3, 1, 0,  0, 0, 0); // 1  add r3
    add(1, 0, 0, 1,  3,  3, 1, 1,  4, 1, 0,  1, 1, 0); // 2  add r4,r3,r3
    add(1, 0, 0, 1,  3,  4, 1, 0,  0, 0, 0,  2, 0, 0); // 3  rt unused
    add(1, 0, 0, 1,  3,  4, 1, 1,  0, 0, 0,  3, 2, 0); // 4
    add(1, 0, 0, 1,  1,  0, 1, 0,  5, 1, 1,  0, 0, 0); // 5  lw r5
    add(1, 0, 0, 1,  5,  1, 1, 1,  6, 1, 0,  0, 0, 1); // 6  sub r6,r5,r1 stall
    add(1, 0, 0, 1,  5,  1, 1, 1,  6, 1, 0,  2, 0, 0); // 7  forward from stage 2
    add(1, 0, 0, 1,  6,  5, 1, 1,  7, 1, 0,  1, 3, 0); // 8  addi r7
    add(1, 0, 0, 1,  7,  0, 1, 0,  7, 1, 0,  1, 0, 0); // 9  ori r7
    add(1, 0, 0, 1,  7,  6, 1, 1,  8, 1, 0,  1, 3, 0); // 10 youngest r7 wins
    add(1, 0, 0, 1,  7,  0, 1, 0,  0, 1, 0,  2, 0, 0); // 11 write r0
    add(1, 0, 0, 1,  0,  0, 1, 1,  0, 0, 0,  0, 0, 0); // 12 read r0
    add(1, 0, 0, 1,  8,  0, 1, 0,  9, 1, 1,  3, 0, 0); // 13 lw r9
    add(1, 0, 1, 1,  9,  9, 1, 1, 10, 1, 0,  0, 0, 0); // 14 flush kills stall
    add(1, 0, 0, 1,  9,  9, 1, 1,  0, 0, 0,  2, 2, 0); // 15
    add(1, 0, 0, 1,  9,  0, 1, 0, 10, 1, 1,  3, 0, 0); // 16 lw r10
    add(1, 0, 0, 1, 10, 10, 0, 1, 11, 1, 0,  0, 0, 1); // 17 rt load-use
    add(0, 0, 0, 1, 10, 10, 0, 1, 11, 1, 0,  0, 0, 0); // 18 reset mid-stall
    add(1, 0, 0, 1, 10, 10, 0, 1, 11, 1, 0,  0, 0, 0); // 19 load dropped
    add(1, 0, 0, 0, 11,  0, 1, 0, 12, 1, 0,  1, 0, 0); // 20 invalid decode
    add(1, 0, 0, 1, 12, 11, 1, 1,  0, 0, 0,  0, 2, 0); // 21 no entry for r12

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i].rstn, tbl[i].frz, tbl[i].fl, tbl[i].v, int'(tbl[i].rs),
            int'(tbl[i].rt), tbl[i].urs, tbl[i].urt, int'(tbl[i].dst),
            tbl[i].wen, tbl[i].ld);
      #1;
      chk3($sformatf("row%0d", i), int'(tbl[i].fa), int'(tbl[i].fb), int'(tbl[i].st));
    end

    // Freeze held during a load-use stall: stall stays, nothing moves.
    @(negedge CLK);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);                 // lw r5
    #1; chk3("frz_lw", 0, 0, 0); chk_cnt("frz_lw", 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      drive(1, 1, 0, 1, 5, 0, 1, 0, 6, 1, 0);               // reader, frozen
      #1; chk3($sformatf("frz_hold%0d", c), 0, 0, 1);
      chk_cnt($sformatf("frz_hold%0d", c), 0);
    end
    @(negedge CLK);
    drive(1, 0, 0, 1, 5, 0, 1, 0, 6, 1, 0);                 // release
    #1; chk3("frz_rel", 0, 0, 1); chk_cnt("frz_rel", 0);
    @(negedge CLK);
    #1; chk3("frz_fwd", 2, 0, 0); chk_cnt("frz_fwd", 1);
    @(negedge CLK);
    drive(1, 0, 0, 1, 5, 6, 1, 1, 0, 0, 0);
    #1; chk3("frz_after", 3, 1, 0);

    // Reset asserted mid-stall, with freeze also high.
    @(negedge CLK);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 12, 1, 1);                // lw r12
    #1; chk3("rst_lw", 0, 0, 0);
    @(negedge CLK);
    drive(1, 0, 0, 1, 12, 12, 1, 1, 13, 1, 0);
    #1; chk3("rst_stall", 0, 0, 1); chk_cnt("rst_stall", 1);
    drive(0, 1, 0, 1, 12, 12, 1, 1, 13, 1, 0);
    #1; chk3("rst_held", 0, 0, 0);
    @(negedge CLK);
    drive(1, 0, 0, 1, 12, 12, 1, 1, 13, 1, 0);
    #1; chk3("rst_after", 0, 0, 0); chk_cnt("rst_after", 0);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: architectural register count; register 0 is hardwired zero.
REQ-002 SHALL have parameter DEPTH, default 3: tracked stages after decode; stage 1 = EX, stage DEPTH = WB.
REQ-003 SHALL have parameter LOAD_STAGE, default 2: first stage whose output carries load data.
REQ-004 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-005 SHALL have port nRST, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port id_valid, input, 1: decode holds a valid instruction.
REQ-007 SHALL have ports id_rs and id_rt, input, $clog2(NREGS) each: decode source registers.
REQ-008 SHALL have ports id_use_rs and id_use_rt, input, 1 each: the matching source is actually read.
REQ-009 SHALL have port id_dst, input, $clog2(NREGS): decode destination register.
REQ-010 SHALL have ports id_wen and id_load, input, 1 each: the instruction writes a register; the instruction is a load.
REQ-011 SHALL have port freeze, input, 1: whole-pipeline hold (cache miss).
REQ-012 SHALL have port flush, input, 1: discard the decode instruction (branch or jump taken).
REQ-013 SHALL have ports fwd_a and fwd_b, output, $clog2(DEPTH+1) each: 0 = register file, k = stage-k result.
REQ-014 SHALL have port stall, output, 1: hold fetch and decode and insert a bubble.

Function
REQ-015 SHALL keep DEPTH entries {valid, dst, wen, load}; entry k describes the instruction in stage k.
REQ-016 On a rising edge with freeze=0, entry k SHALL take entry k-1 for k>1, and the entry in stage DEPTH SHALL retire.
REQ-017 Entry 1 SHALL load the decode fields when id_valid & ~stall & ~flush; otherwise entry 1 SHALL load a bubble (valid=0).
REQ-018 With freeze=1, all entries SHALL hold their values.
REQ-019 For each source with use=1 and reg≠0, fwd SHALL be the smallest k where entry k is valid, wen=1 and dst equals the source; otherwise fwd SHALL be 0.
REQ-020 The youngest match SHALL take priority over older matches (WAW correctness).
REQ-021 stall SHALL be 1 when any used source's youngest match has load=1 and k<LOAD_STAGE; in that case the fwd for that source SHALL be 0.
REQ-022 flush=1 SHALL force stall=0.
REQ-023 fwd and stall SHALL be combinational from the entries and decode inputs, with zero latency.
REQ-024 A source of register 0, or a source with use=0, SHALL never cause a match or a stall.
REQ-025 After a load-use stall, the bubble SHALL advance the load to stage LOAD_STAGE; the next cycle SHALL forward with fwd=LOAD_STAGE and stall=0.
REQ-026 Asserting freeze during a stall SHALL keep stall asserted and insert no additional bubble.

Reset
REQ-027 On nRST=0 at a rising edge, all entries SHALL clear to valid=0, regardless of freeze or flush.
REQ-028 During and immediately after reset, stall=0 and fwd_a=fwd_b=0.
REQ-029 Reset asserted mid-stall SHALL drop the in-flight load with no residual stall.

Configuration
REQ-030 With macro HAZARD_STATS_EN defined, the block SHALL have output stall_cycles, 16 bits, reset to 0; it increments on each edge with stall & ~freeze and saturates at 16'hFFFF.
REQ-031 Without HAZARD_STATS_EN, the block SHALL have no stall_cycles port and no counter logic.

Structure
REQ-032 Package hazard_pkg SHALL hold the sb_entry_t struct and the default constants for NREGS, DEPTH and LOAD_STAGE.
REQ-033 Sub-module hazard_match SHALL perform the per-source priority search and be instantiated twice (rs, rt).

Verification
REQ-034 Scenario: add r3 issued, then add r4,r3,r3 next cycle -> fwd_a=1, fwd_b=1, stall=0.
REQ-035 Scenario: lw r5 issued, then sub r6,r5,r1 next cycle -> stall=1 for one cycle with fwd_a=0; next cycle fwd_a=2, stall=0; stall_cycles=1.
REQ-036 Scenario: addi r7 issued, then ori r7, then a reader of r7 -> fwd_a=1 (youngest), not 2.
REQ-037 Scenario: reader of r0 behind a write to r0 -> fwd=0, stall=0.
REQ-038 Scenario: lw r5 then dependent reader with freeze=1 held 4 cycles -> stall stays 1, entries hold, stall_cycles unchanged; release -> one bubble only.
REQ-039 Scenario: flush=1 with a dependent load-use -> stall=0 and entry 1 becomes a bubble; nRST=0 mid-stream -> all fwd=0 next cycle.
